// File: rtl/datapath_bus.sv
// Multicycle RV32 datapath with an external valid/ready memory bus and a built-in access sequencer.
// Define DATAPATH_SUBWORD_EN (WORD_SIZE = 32 only) for funct3-qualified byte/half data accesses.
module datapath_bus #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adr_src,
  input  logic                   pc_write,
  input  logic                   ir_write,
  input  logic                   reg_write,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [2:0]             imm_sel,
  input  logic [1:0]             alu_src_a,
  input  logic [1:0]             alu_src_b,
  input  logic [3:0]             alu_ctrl,
  input  logic [1:0]             out_sel,
  input  logic                   output_en,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output logic                   zero_flag,
  output logic                   mem_busy,
  output logic                   mem_done,
  output logic                   mem_err,
  output logic [WORD_SIZE-1:0]   data_out,
  output logic                   bus_valid,
  output logic                   bus_we,
  output logic [WORD_SIZE-1:0]   bus_addr,
  output logic [WORD_SIZE-1:0]   bus_wdata,
  output logic [WORD_SIZE/8-1:0] bus_wstrb,
  input  logic                   bus_ready,
  input  logic [WORD_SIZE-1:0]   bus_rdata,
  input  logic                   bus_err
);

  localparam int unsigned StrbW = WORD_SIZE / 8;
  localparam int unsigned ShW   = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {StIdle, StReq, StDone} seq_state_e;

  seq_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, oldpc_q, ir_q, a_q, b_q, alu_q;
  logic [WORD_SIZE-1:0] mdr_q, mdr_d;
  logic [WORD_SIZE-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [StrbW-1:0]     bus_wstrb_q, bus_wstrb_d;
  logic                 bus_we_q, bus_we_d, err_q, err_d;
  logic [WORD_SIZE-1:0] rf_q [32];

  logic [4:0]           rs1, rs2, rd;
  logic [31:0]          imm32;
  logic [WORD_SIZE-1:0] imm_ext, src_a, src_b, alu_res, out_bus, adr_mux, load_val;
  logic [ShW-1:0]       shamt;

`ifdef DATAPATH_SUBWORD_EN
  logic       sub_q, sub_d;
  logic [2:0] f3_q, f3_d;
  logic       misal;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
`endif

  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign rd     = ir_q[11:7];
  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      3'd0:    imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1:    imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2:    imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3:    imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'd4:    imm32 = {ir_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm_ext = WORD_SIZE'($signed(imm32));

  always_comb begin
    src_a = '0;
    case (alu_src_a)
      2'd0:    src_a = oldpc_q;
      2'd1:    src_a = pc_q;
      2'd2:    src_a = a_q;
      default: src_a = '0;
    endcase
    src_b = '0;
    case (alu_src_b)
      2'd0:    src_b = b_q;
      2'd1:    src_b = imm_ext;
      2'd2:    src_b = WORD_SIZE'(4);
      default: src_b = '0;
    endcase
  end

  assign shamt = src_b[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      4'd0:    alu_res = src_a + src_b;
      4'd1:    alu_res = src_a - src_b;
      4'd2:    alu_res = src_a & src_b;
      4'd3:    alu_res = src_a | src_b;
      4'd4:    alu_res = src_a ^ src_b;
      4'd5:    alu_res = WORD_SIZE'($signed(src_a) < $signed(src_b));
      4'd6:    alu_res = WORD_SIZE'(src_a < src_b);
      4'd7:    alu_res = src_a << shamt;
      4'd8:    alu_res = src_a >> shamt;
      4'd9:    alu_res = WORD_SIZE'($signed(src_a) >>> shamt);
      4'd10:   alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  assign zero_flag = (alu_res == '0);

  always_comb begin
    out_bus = '0;
    case (out_sel)
      2'd0:    out_bus = alu_q;
      2'd1:    out_bus = alu_res;
      2'd2:    out_bus = mdr_q;
      default: out_bus = '0;
    endcase
  end

  // Gated by reset too so the output reads zero while the block is held in reset.
  assign data_out = (output_en && rst) ? out_bus : '0;
  assign adr_mux  = adr_src ? out_bus : pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      oldpc_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (pc_write) pc_q <= out_bus;
      if (ir_write) begin
        ir_q    <= mdr_q;
        oldpc_q <= pc_q;
      end
      a_q   <= rf_q[rs1];
      b_q   <= rf_q[rs2];
      alu_q <= alu_res;
      if (reg_write && (rd != 5'd0)) rf_q[rd] <= out_bus;
    end
  end

  always_comb begin
    load_val = bus_rdata;
`ifdef DATAPATH_SUBWORD_EN
    lane_b = bus_rdata[7:0];
    case (bus_addr_q[1:0])
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      2'd3:    lane_b = bus_rdata[31:24];
      default: lane_b = bus_rdata[7:0];
    endcase
    lane_h = bus_addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (sub_q) begin
      case (f3_q)
        3'b000:  load_val = WORD_SIZE'({{24{lane_b[7]}}, lane_b});
        3'b100:  load_val = WORD_SIZE'({24'b0, lane_b});
        3'b001:  load_val = WORD_SIZE'({{16{lane_h[15]}}, lane_h});
        3'b101:  load_val = WORD_SIZE'({16'b0, lane_h});
        default: load_val = bus_rdata;
      endcase
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_we_d    = bus_we_q;
    err_d       = err_q;
    mdr_d       = mdr_q;
`ifdef DATAPATH_SUBWORD_EN
    sub_d = sub_q;
    f3_d  = f3_q;
    misal = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          bus_addr_d  = adr_mux;
          bus_wdata_d = b_q;
          bus_we_d    = mem_we;
          bus_wstrb_d = '1;
          err_d       = 1'b0;
          state_d     = StReq;
`ifdef DATAPATH_SUBWORD_EN
          sub_d = adr_src;
          f3_d  = ir_q[14:12];
          if (adr_src) begin
            case (ir_q[13:12])
              2'b00: begin
                bus_wdata_d = WORD_SIZE'({4{b_q[7:0]}});
                bus_wstrb_d = StrbW'(4'b0001 << adr_mux[1:0]);
              end
              2'b01: begin
                bus_wdata_d = WORD_SIZE'({2{b_q[15:0]}});
                bus_wstrb_d = adr_mux[1] ? StrbW'(4'b1100) : StrbW'(4'b0011);
                misal       = adr_mux[0];
              end
              default: misal = |adr_mux[1:0];
            endcase
            // Misaligned accesses never reach the bus; they report the error directly.
            if (misal) begin
              err_d       = 1'b1;
              bus_wstrb_d = '0;
              state_d     = StDone;
            end
          end
`endif
        end
      end
      StReq: begin
        if (bus_ready) begin
          err_d = bus_err;
          if (!bus_we_q && !bus_err) mdr_d = load_val;
          state_d = StDone;
        end
      end
      StDone: begin
        bus_we_d    = 1'b0;
        bus_wstrb_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      bus_we_q    <= 1'b0;
      err_q       <= 1'b0;
      mdr_q       <= '0;
`ifdef DATAPATH_SUBWORD_EN
      sub_q <= 1'b0;
      f3_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_we_q    <= bus_we_d;
      err_q       <= err_d;
      mdr_q       <= mdr_d;
`ifdef DATAPATH_SUBWORD_EN
      sub_q <= sub_d;
      f3_q  <= f3_d;
`endif
    end
  end

  assign bus_valid = (state_q == StReq);
  assign mem_busy  = (state_q != StIdle);
  assign mem_done  = (state_q == StDone);
  assign mem_err   = mem_done & err_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_datapath_bus.sv
// Randomized bench for datapath_bus: a bus slave driven from tasks plus an architectural model
// (PC, IR, MDR, register array) that predicts bus requests, MDR contents and ALU results.
module tb_datapath_bus;

  localparam int unsigned W     = 32;
  localparam logic [31:0] RstPc = 32'h0000_0040;

  logic        clk, rst_n;
  logic        adr_src, pc_write, ir_write, reg_write, mem_req, mem_we;
  logic [2:0]  imm_sel;
  logic [1:0]  alu_src_a, alu_src_b, out_sel;
  logic [3:0]  alu_ctrl;
  logic        output_en;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        zero_flag, mem_busy, mem_done, mem_err;
  logic [31:0] data_out, bus_addr, bus_wdata, bus_rdata;
  logic        bus_valid, bus_we, bus_ready, bus_err;
  logic [3:0]  bus_wstrb;

  datapath_bus #(.WORD_SIZE(W), .RESET_PC(RstPc)) dut (
    .clk(clk), .rst(rst_n), .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .out_sel(out_sel),
    .output_en(output_en), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero_flag(zero_flag), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
    .data_out(data_out), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_pc, ref_ir, ref_mdr;
  logic [31:0] ref_rf [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic model_reset();
    ref_pc  = RstPc;
    ref_ir  = '0;
    ref_mdr = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
  endtask

  // One bus transaction; load_exp is what the MDR should hold after a successful read.
  task automatic access(input logic we, input logic src, input int waits,
                        input logic [31:0] rdata, input logic err, input logic poke,
                        input logic [31:0] load_exp);
    logic [31:0] exp_addr, exp_wdata;
    exp_addr  = src ? ref_mdr : ref_pc;
    exp_wdata = ref_rf[ref_ir[24:20]];
    out_sel   = 2'd2;
    adr_src   = src;
    mem_we    = we;
    mem_req   = 1'b1;
    next_cycle();
    mem_req = 1'b0;
    mem_we  = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check_eq("req_valid", 32'(bus_valid), 32'd1);
      check_eq("req_addr", bus_addr, exp_addr);
      check_eq("req_we", 32'(bus_we), 32'(we));
      check_eq("done_early", 32'(mem_done), 32'd0);
      if (we) begin
        check_eq("req_wdata", bus_wdata, exp_wdata);
        check_eq("req_wstrb", 32'(bus_wstrb), 32'hf);
      end
      if (i == waits) begin
        bus_ready = 1'b1;
        bus_rdata = rdata;
        bus_err   = err;
      end else if (poke) begin
        mem_req  = 1'b1;
        pc_write = 1'b1;
        ref_pc   = ref_mdr;
      end
      next_cycle();
      bus_ready = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = $urandom;
      mem_req   = 1'b0;
      pc_write  = 1'b0;
    end
    check_eq("done_pulse", 32'(mem_done), 32'd1);
    check_eq("done_err", 32'(mem_err), 32'(err));
    check_eq("done_valid", 32'(bus_valid), 32'd0);
    if (!we && !err) ref_mdr = load_exp;
    check_eq("mdr", data_out, ref_mdr);
    mem_req = poke;
    next_cycle();
    mem_req = 1'b0;
    check_eq("done_single", 32'(mem_done), 32'd0);
    check_eq("idle_after", 32'(mem_busy), 32'd0);
  endtask

  task automatic do_ir_write();
    ir_write = 1'b1;
    next_cycle();
    ir_write = 1'b0;
    ref_ir   = ref_mdr;
    check_eq("opcode", 32'(opcode), 32'(ref_ir[6:0]));
    check_eq("funct3", 32'(funct3), 32'(ref_ir[14:12]));
    check_eq("funct7", 32'(funct7), 32'(ref_ir[31:25]));
  endtask

  task automatic do_reg_write();
    out_sel   = 2'd2;
    reg_write = 1'b1;
    next_cycle();
    reg_write = 1'b0;
    if (ref_ir[11:7] != 5'd0) ref_rf[ref_ir[11:7]] = ref_mdr;
  endtask

  task automatic do_pc_write();
    out_sel  = 2'd2;
    pc_write = 1'b1;
    next_cycle();
    pc_write = 1'b0;
    ref_pc   = ref_mdr;
  endtask

  // Needs A/B settled: call at least one cycle after the last IR or register update.
  task automatic alu_checks();
    logic [31:0] rs1v, rs2v, immi, sum;
    rs1v = ref_rf[ref_ir[19:15]];
    rs2v = ref_rf[ref_ir[24:20]];
    immi = {{20{ref_ir[31]}}, ref_ir[31:20]};
    out_sel = 2'd1; alu_src_a = 2'd1; alu_src_b = 2'd2; alu_ctrl = 4'd0;
    #1 check_eq("pc_plus4", data_out, ref_pc + 32'd4);
    alu_src_a = 2'd2; alu_src_b = 2'd0;
    #1 check_eq("a_plus_b", data_out, rs1v + rs2v);
    alu_ctrl = 4'd1;
    #1 check_eq("a_eq_b_zero", 32'(zero_flag), 32'(rs1v == rs2v));
    alu_src_a = 2'd1; alu_src_b = 2'd1; alu_ctrl = 4'd0; imm_sel = 3'd0;
    sum = ref_pc + immi;
    #1 check_eq("pc_plus_imm", data_out, sum);
    next_cycle();
    out_sel = 2'd0;
    #1 check_eq("alu_reg", data_out, sum);
    out_sel = 2'd2; alu_src_a = 2'd0; alu_src_b = 2'd0;
  endtask

  initial begin
    logic [31:0] instr, data;
    rst_n = 1'b0;
    {adr_src, pc_write, ir_write, reg_write, mem_req, mem_we} = '0;
    imm_sel = '0; alu_src_a = '0; alu_src_b = '0; alu_ctrl = '0;
    out_sel = 2'd2; output_en = 1'b1;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_data_out", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_busy", 32'(mem_busy), 32'd0);
    check_eq("rst_done", 32'(mem_done), 32'd0);
    check_eq("rst_err", 32'(mem_err), 32'd0);
    check_eq("rst_we", 32'(bus_we), 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    check_eq("rst_wstrb", 32'(bus_wstrb), 32'd0);
    check_eq("rst_opcode", 32'(opcode), 32'd0);
    check_eq("rst_mdr", data_out, 32'd0);
    out_sel = 2'd1; alu_src_a = 2'd1; alu_src_b = 2'd2; alu_ctrl = 4'd0;
    #1 check_eq("rst_pc", data_out, RstPc + 32'd4);
    output_en = 1'b0;
    #1 check_eq("gated_out", data_out, 32'd0);
    output_en = 1'b1; out_sel = 2'd2; alu_src_a = 2'd0; alu_src_b = 2'd0;
    @(negedge clk);

    // Zero-wait fetch of addi x1, x0, 5.
    access(1'b0, 1'b0, 0, 32'h0050_0093, 1'b0, 1'b0, 32'h0050_0093);
    do_ir_write();
    check_eq("fetch_opcode", 32'(opcode), 32'h13);
    check_eq("fetch_funct3", 32'(funct3), 32'd0);

    // Five wait states with requests and PC updates poked while busy.
    access(1'b0, 1'b0, 5, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678);
    // Errored read leaves the MDR alone.
    access(1'b0, 1'b0, 1, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0);

`ifndef DATAPATH_SUBWORD_EN
    // Store of 0xDEADBEEF from x2 to 0x100.
    access(1'b0, 1'b0, 0, 32'h0020_0123, 1'b0, 1'b0, 32'h0020_0123);
    do_ir_write();
    idle(1);
    access(1'b0, 1'b1, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF);
    do_reg_write();
    access(1'b0, 1'b0, 0, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0100);
    idle(1);
    access(1'b1, 1'b1, 2, $urandom, 1'b0, 1'b0, 32'h0);
    check_eq("store_mdr_kept", data_out, 32'h0000_0100);

    for (int it = 0; it < 30; it++) begin
      instr = $urandom;
      data  = $urandom;
      access(1'b0, 1'b0, $urandom_range(0, 4), instr, ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), instr);
      do_ir_write();
      idle(1);
      alu_checks();
      access(1'b0, 1'b1, $urandom_range(0, 4), data, ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), data);
      do_reg_write();
      idle(2);
      access(1'b1, 1'b1, $urandom_range(0, 4), $urandom, ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)), 32'h0);
      if ($urandom_range(0, 1) == 1) do_pc_write();
    end
`else
    // lb from 0x103: fetch an lb opcode, then a word used as the data address.
    access(1'b0, 1'b0, 0, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0003);
    do_ir_write();
    access(1'b0, 1'b0, 0, 32'h0000_0103, 1'b0, 1'b0, 32'h0000_0103);
    access(1'b0, 1'b1, 1, 32'h8011_2233, 1'b0, 1'b0, 32'hFFFF_FF80);
    // lhu from 0x101 is misaligned and never reaches the bus.
    access(1'b0, 1'b0, 0, 32'h0000_5003, 1'b0, 1'b0, 32'h0000_5003);
    do_ir_write();
    access(1'b0, 1'b0, 0, 32'h0000_0101, 1'b0, 1'b0, 32'h0000_0101);
    adr_src = 1'b1; out_sel = 2'd2; mem_req = 1'b1;
    next_cycle();
    mem_req = 1'b0;
    check_eq("misal_done", 32'(mem_done), 32'd1);
    check_eq("misal_err", 32'(mem_err), 32'd1);
    check_eq("misal_valid", 32'(bus_valid), 32'd0);
    check_eq("misal_mdr", data_out, ref_mdr);
    next_cycle();
    check_eq("misal_idle", 32'(mem_busy), 32'd0);
`endif

    // Reset pulled while the request is outstanding.
    adr_src = 1'b0; mem_req = 1'b1;
    next_cycle();
    mem_req = 1'b0;
    check_eq("pre_rst_valid", 32'(bus_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(mem_busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_sel = 2'd1; alu_src_a = 2'd1; alu_src_b = 2'd2; alu_ctrl = 4'd0;
    #1 check_eq("mid_rst_pc", data_out, RstPc + 32'd4);
    check_eq("mid_rst_valid_after", 32'(bus_valid), 32'd0);
    out_sel = 2'd2; alu_src_a = 2'd0; alu_src_b = 2'd0;
    @(negedge clk);
    access(1'b0, 1'b0, 2, 32'h0000_0013, 1'b0, 1'b0, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_bus.md
# datapath_bus

Multicycle RV32 datapath whose memory is external. The unified memory is replaced by a valid/ready bus master port with a built-in access sequencer, so instruction and data accesses can take any number of wait states. The block still holds PC, IR, old-PC, A/B, ALU-result and memory-data registers, and reuses `register_file`, `extend` and `alu`. It sits under the multicycle controller, which issues `mem_req` and waits for `mem_done`.

## Interface
- `WORD_SIZE`, 32: datapath and bus data width; a multiple of 8.
- `RESET_PC`, 0: value loaded into PC on reset.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (low = reset).
- `adr_src`  in  1  0: access PC; 1: access `out_bus`.
- `pc_write`, `ir_write`, `reg_write`  in  1  load PC / load IR and old-PC / write regfile.
- `mem_req`  in  1  start a bus access (sampled in IDLE only).
- `mem_we`  in  1  the access is a store (sampled with `mem_req`).
- `imm_sel`  in  3  immediate format to `extend`.
- `alu_src_a`  in  2  0: old-PC, 1: PC, 2: A reg.
- `alu_src_b`  in  2  0: B reg, 1: immediate, 2: constant 4.
- `alu_ctrl`  in  4  ALU operation.
- `out_sel`  in  2  0: ALU reg, 1: ALU comb, 2: MDR.
- `output_en`  in  1  drive `data_out`; else 0.
- `opcode`/`funct3`/`funct7`  out  7/3/7  IR fields.
- `zero_flag`  out  1  ALU zero.
- `mem_busy`  out  1  sequencer not IDLE.
- `mem_done`  out  1  one-cycle pulse when an access completes.
- `mem_err`  out  1  qualifies `mem_done`: the bus signalled an error.
- `data_out`  out  WORD_SIZE  gated `out_bus`.
- `bus_valid`  out  1  request valid.
- `bus_we`  out  1  write request.
- `bus_addr`  out  WORD_SIZE  byte address.
- `bus_wdata`  out  WORD_SIZE  write data.
- `bus_wstrb`  out  WORD_SIZE/8  byte strobes.
- `bus_ready`  in  1  slave accepts or completes this cycle.
- `bus_rdata`  in  WORD_SIZE  read data, valid with `bus_ready`.
- `bus_err`  in  1  error, valid with `bus_ready`.

## Operation
- **Sequencer states:** IDLE, REQ, DONE.
- **IDLE:**
  - `mem_req=1` latches `bus_addr` from the address mux, `bus_wdata` from the B reg, and `bus_we` from `mem_we`.
  - Next state is REQ.
- **REQ:**
  - `bus_valid=1`; address, data, strobes and `bus_we` are held stable.
  - `bus_ready=1` ends the access. On a read with `bus_err=0`, `bus_rdata` is captured into the MDR. Next state is DONE.
  - `bus_ready=0` stays in REQ; there is no timeout.
- **DONE:**
  - `mem_done=1` and `mem_err` = latched `bus_err`.
  - Next state is IDLE.
- **Ignored requests:** `mem_req` is ignored in REQ and DONE; nothing is queued.
- **MDR on store or error:** the MDR keeps its old value.
- **`ir_write`:** IR ← MDR and old-PC ← PC. It is legal in the DONE cycle or any later cycle.
- **Register updates:**
  - PC ← `out_bus` on `pc_write`; the regfile writes `out_bus` to rd on `reg_write`.
  - A, B and ALU regs load every cycle.
- **`pc_write` during a transaction:** allowed; it does not disturb the latched `bus_addr`.
- **Reset:** asynchronous. State goes to IDLE; `bus_valid`, `bus_we`, `mem_done` and `mem_err` go to 0; PC = `RESET_PC`; all other registers, `bus_addr`, `bus_wdata` and `data_out` go to 0. `bus_wstrb` resets to 0 (it is all-ones only while a request is latched).
- **Reset during REQ:** drops `bus_valid` immediately. The slave must tolerate an abandoned request.

## Timing
- `mem_req` asserted in cycle N (IDLE):
  - `bus_valid` rises in N+1.
  - With `bus_ready` in N+k (k≥1), `mem_done` is asserted in N+k+1 and the MDR is valid in N+k+1.
- Minimum access latency: `mem_req` to `mem_done` = 2 cycles.
- A back-to-back `mem_req` is accepted in the cycle after DONE at the earliest.
- `ir_write` in cycle D makes IR and `opcode` valid in D+1.
- `out_bus` and `zero_flag` are combinational from the registers and control inputs.

## Configuration
- **`DATAPATH_SUBWORD_EN` defined (WORD_SIZE must be 32):** IR `funct3` qualifies every data access.
  - Byte (000/100) or half (001/101) stores replicate the low lane across `bus_wdata`.
  - `bus_wstrb` is set from `bus_addr[1:0]`: one bit for a byte, two for a half.
  - Loads extract the addressed lane, then sign-extend (000/001) or zero-extend (100/101) into the MDR.
  - Fetches (`adr_src=0`) are always full word.
  - A misaligned half/word access completes with `mem_err=1` and no `bus_valid`: IDLE→DONE in one step, `mem_done` at N+1.
- **Undefined:** `bus_wstrb` is all ones; the MDR always takes the full `bus_rdata`; there is no alignment check.

## Test plan
- **Zero-wait fetch:** after reset, `mem_req=1`, `adr_src=0`, slave ready immediately with `bus_rdata=0x00500093` → `bus_addr=RESET_PC`; `mem_done` 2 cycles after `mem_req`; after `ir_write`, `opcode=0x13`, `funct3=0`.
- **Wait states:** slave holds `bus_ready=0` for 5 cycles → `bus_valid` and `bus_addr` stay stable for 6 cycles; `mem_done` is a single pulse; a second `mem_req` while busy is ignored.
- **Store:** B=0xDEADBEEF, `adr_src=1`, `out_bus=0x100`, `mem_we=1` → `bus_we=1`, `bus_addr=0x100`, `bus_wdata=0xDEADBEEF`, `bus_wstrb=0xF`; MDR unchanged.
- **Bus error:** a read completes with `bus_err=1` → `mem_done=1` with `mem_err=1`; MDR keeps its previous value.
- **Reset mid-access:** `rst` is pulled low while in REQ → `bus_valid=0` asynchronously; PC=`RESET_PC`; `mem_busy=0`.
- **`DATAPATH_SUBWORD_EN`, sub-word loads:** lb (`funct3=000`) at 0x103 with `bus_rdata=0x80112233` → MDR=0xFFFFFF80; lhu (`funct3=101`) at 0x101 → `mem_err=1`, `bus_valid` never asserted.
